// File: rtl/if_fetch_stage_pkg.sv
// Shared core definitions: instruction width, field positions, opcodes and a
// small ring-pointer helper used by the fetch-side FIFOs.
package if_fetch_stage_pkg;

  localparam int INSTR_W = 16;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
    OP_XOR  = 4'h4, OP_SHL  = 4'h5, OP_SHR  = 4'h6, OP_ADDI = 4'h7,
    OP_LD   = 4'h8, OP_ST   = 4'h9, OP_BEQ  = 4'hA, OP_BNE  = 4'hB,
    OP_JAL  = 4'hC, OP_JR   = 4'hD, OP_LUI  = 4'hE, OP_NOP  = 4'hF
  } opcode_e;

  // Advance a ring index that wraps at an arbitrary (non power-of-two) depth.
  function automatic int ring_next(input int p, input int depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/if_fetch_stage_fetch_queue.sv
// In-order instruction queue holding {pc, instr}; head is read combinationally
// so the fetch stage can present the oldest entry in the same cycle.
module fetch_queue
  import if_fetch_stage_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int ENTRY_W = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ENTRY_W-1:0]           push_data,
  output logic [ENTRY_W-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr_reg] <= push_data;
        wr_ptr_reg      <= PTR_W'(ring_next(int'(wr_ptr_reg), DEPTH));
      end
      if (pop) begin
        rd_ptr_reg <= PTR_W'(ring_next(int'(rd_ptr_reg), DEPTH));
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(push && count_reg == CNT_W'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(pop && count_reg == '0));

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches,
// queues returned words and presents decoded fields to ID.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_stall,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [3:0]         if_opcode,
  output logic [3:0]         if_rd,
  output logic [3:0]         if_rs1,
  output logic [3:0]         if_rs2,
  output logic [7:0]         if_imm_off
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int SUM_W   = CNT_W + 1;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  pc_reg;
  logic [CNT_W-1:0]   inflight_reg;
  logic [CNT_W-1:0]   drop_reg;
  logic [ADDR_W-1:0]  pc_fifo [DEPTH];
  logic [PTR_W-1:0]   pf_wr_reg;
  logic [PTR_W-1:0]   pf_rd_reg;

  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] q_head;
  logic [ADDR_W-1:0]  head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic               fire;
  logic               q_push;
  logic               q_pop;

  // Credit check uses registered state only; with a 1-cycle memory this caps
  // sustained fetch at two instructions every three cycles.
  assign imem_req  = !rst && !redirect_valid &&
                     ((SUM_W'(count) + SUM_W'(inflight_reg)) < SUM_W'(DEPTH));
  assign imem_addr = pc_reg;
  assign fire      = imem_req && imem_gnt;

  assign q_push = imem_rvalid && (drop_reg == '0) && !redirect_valid;
  assign q_pop  = if_valid && !id_stall && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      inflight_reg <= '0;
      drop_reg     <= '0;
      pf_wr_reg    <= '0;
      pf_rd_reg    <= '0;
    end else begin
      // The PC FIFO advances on every response, dropped or not, so it stays
      // aligned with the memory's in-order return stream.
      if (fire) begin
        pc_fifo[pf_wr_reg] <= pc_reg;
        pf_wr_reg          <= PTR_W'(ring_next(int'(pf_wr_reg), DEPTH));
      end
      if (imem_rvalid) begin
        pf_rd_reg <= PTR_W'(ring_next(int'(pf_rd_reg), DEPTH));
      end
      inflight_reg <= inflight_reg + CNT_W'(fire) - CNT_W'(imem_rvalid);
      if (redirect_valid) begin
        pc_reg   <= redirect_pc;
        drop_reg <= inflight_reg - CNT_W'(imem_rvalid);
      end else begin
        if (fire) pc_reg <= pc_reg + 1'b1;
        if (imem_rvalid && drop_reg != '0) drop_reg <= drop_reg - 1'b1;
      end
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (q_push),
    .pop       (q_pop),
    .push_data ({pc_fifo[pf_rd_reg], imem_rdata}),
    .head      (q_head),
    .count     (count)
  );

  assign if_valid                = (count != '0);
  assign {head_pc, head_instr}   = if_valid ? q_head : '0;
  assign if_pc      = head_pc;
  assign if_opcode  = head_instr[OPC_MSB:OPC_LSB];
  assign if_rd      = head_instr[RD_MSB:RD_LSB];
  assign if_rs1     = head_instr[RS1_MSB:RS1_LSB];
  assign if_rs2     = head_instr[RS2_MSB:RS2_LSB];
  assign if_imm_off = head_instr[IMM_MSB:IMM_LSB];

  a_gnt_needs_req: assert property (@(posedge clk) disable iff (rst)
    imem_gnt |-> imem_req);
  a_rvalid_needs_inflight: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> inflight_reg != '0);
  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (imem_req && !imem_gnt) |=> (redirect_valid || (imem_req && $stable(imem_addr))));

endmodule
